// File: rtl/afu_stream_ctrl_if.sv
// Host, engine and job-control signals of the AFU stream controller.
// slave is the controller side; master is the host/engine side.
interface afu_stream_ctrl_if #(
    parameter int DATA_WIDTH      = 512,
    parameter int BUFF_DEPTH_BITS = 5
);
    logic [DATA_WIDTH-1:0]    input_fifo_din;
    logic                     input_fifo_we;
    logic                     input_fifo_full;
    logic                     input_fifo_almost_full;
    logic [BUFF_DEPTH_BITS:0] input_fifo_count;
    logic [DATA_WIDTH-1:0]    output_fifo_dout;
    logic                     output_fifo_re;
    logic                     output_fifo_empty;
    logic                     output_fifo_almost_empty;
    logic [31:0]              ctx_length;
    logic                     ctx_mode;
    logic                     ctx_start;
    logic                     ctx_busy;
    logic                     ctx_done;
    logic [DATA_WIDTH-1:0]    eng_in_data;
    logic                     eng_in_valid;
    logic [DATA_WIDTH-1:0]    eng_out_data;
    logic                     eng_out_valid;
    logic [31:0]              lines_out;
    logic                     err_unexpected;

    modport slave (
        input  input_fifo_din, input_fifo_we, output_fifo_re,
               ctx_length, ctx_mode, ctx_start, eng_out_data, eng_out_valid,
        output input_fifo_full, input_fifo_almost_full, input_fifo_count,
               output_fifo_dout, output_fifo_empty, output_fifo_almost_empty,
               ctx_busy, ctx_done, eng_in_data, eng_in_valid, lines_out, err_unexpected
    );

    modport master (
        output input_fifo_din, input_fifo_we, output_fifo_re,
               ctx_length, ctx_mode, ctx_start, eng_out_data, eng_out_valid,
        input  input_fifo_full, input_fifo_almost_full, input_fifo_count,
               output_fifo_dout, output_fifo_empty, output_fifo_almost_empty,
               ctx_busy, ctx_done, eng_in_data, eng_in_valid, lines_out, err_unexpected
    );
endinterface

// File: rtl/afu_stream_ctrl.sv
// Input FIFO -> external transform engine (or bypass) -> output FIFO, with
// credit flow control so engine results can never overflow the output FIFO.
module afu_stream_ctrl #(
    parameter int DATA_WIDTH             = 512,
    parameter int BUFF_DEPTH_BITS        = 5,
    parameter int ALMOST_FULL_MARGIN     = 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
    input logic              clk,
    input logic              reset,
    afu_stream_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** BUFF_DEPTH_BITS;
    typedef logic [BUFF_DEPTH_BITS:0]   cnt_t;
    typedef logic [BUFF_DEPTH_BITS-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
    localparam cnt_t AF_LEVEL = cnt_t'(DEPTH - ALMOST_FULL_MARGIN);
    localparam cnt_t AE_LEVEL = cnt_t'(ALMOST_EMPTY_THRESHOLD);

    state_t                state, next_state;
    logic [31:0]           len_q, issued, lines_cnt;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] in_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] out_mem [DEPTH];
    ptr_t                  in_wp, in_rp, out_wp, out_rp;
    cnt_t                  in_cnt, out_cnt, credits, outstanding;
    logic [DATA_WIDTH-1:0] line_q, wr_data, dout_q;
    logic                  eng_v_q, byp_v_q, wr_v, err_q;
    logic                  in_full, in_push, out_full, out_empty, out_push, out_pop;
    logic                  issue, accept_start, eng_acc;

    always_comb begin
        in_full      = (in_cnt == DEPTH_C);
        in_push      = bus.input_fifo_we && !in_full;
        out_full     = (out_cnt == DEPTH_C);
        out_empty    = (out_cnt == '0);
        out_push     = wr_v && !out_full;
        out_pop      = bus.output_fifo_re && !out_empty;
        issue        = (state == RUN) && (in_cnt != '0) && (credits != '0) && (issued < len_q);
        accept_start = bus.ctx_start && ((state == IDLE) || (state == DONE));
        eng_acc      = bus.eng_out_valid && (outstanding != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // ctx_done also covers the last DRAIN cycle so it rises together with the final write
    always_comb begin
        next_state   = state;
        bus.ctx_busy = (state == RUN) || (state == DRAIN);
        bus.ctx_done = (state == DONE) || ((state == DRAIN) && (lines_cnt == len_q));
        unique case (state)
            IDLE, DONE: if (accept_start) next_state = (bus.ctx_length == '0) ? DONE : RUN;
            RUN:        if (issued == len_q) next_state = DRAIN;
            DRAIN:      if (lines_cnt == len_q) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            mode_q    <= 1'b0;
            issued    <= '0;
            lines_cnt <= '0;
        end else if (accept_start) begin
            len_q     <= bus.ctx_length;
            mode_q    <= bus.ctx_mode;
            issued    <= '0;
            lines_cnt <= '0;
        end else begin
            issued    <= issued + 32'(issue);
            lines_cnt <= lines_cnt + 32'(out_push);
        end
    end

    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wp]   <= bus.input_fifo_din;
        if (out_push) out_mem[out_wp] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wp  <= '0;
            in_rp  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + ptr_t'(1);
            if (issue)   in_rp <= in_rp + ptr_t'(1);
            in_cnt <= in_cnt + cnt_t'(in_push) - cnt_t'(issue);
        end
    end

    // Issue stage: the popped line is presented one cycle later, to the engine or bypass
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_v_q <= 1'b0;
            byp_v_q <= 1'b0;
            line_q  <= '0;
        end else begin
            eng_v_q <= issue && !mode_q;
            byp_v_q <= issue && mode_q;
            if (issue) line_q <= in_mem[in_rp];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_v        <= 1'b0;
            wr_data     <= '0;
            err_q       <= 1'b0;
            outstanding <= '0;
        end else begin
            wr_v <= byp_v_q || eng_acc;
            if (byp_v_q)      wr_data <= line_q;
            else if (eng_acc) wr_data <= bus.eng_out_data;
            err_q       <= err_q || (bus.eng_out_valid && (outstanding == '0));
            outstanding <= outstanding + cnt_t'(eng_v_q) - cnt_t'(eng_acc);
        end
    end

    // A credit is held from issue until the line leaves the output FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wp  <= '0;
            out_rp  <= '0;
            out_cnt <= '0;
            dout_q  <= '0;
            credits <= DEPTH_C;
        end else begin
            if (out_push) out_wp <= out_wp + ptr_t'(1);
            if (out_pop) begin
                out_rp <= out_rp + ptr_t'(1);
                dout_q <= out_mem[out_rp];
            end
            out_cnt <= out_cnt + cnt_t'(out_push) - cnt_t'(out_pop);
            credits <= credits - cnt_t'(issue) + cnt_t'(out_pop);
        end
    end

    assign bus.input_fifo_full          = in_full;
    assign bus.input_fifo_almost_full   = (in_cnt >= AF_LEVEL);
    assign bus.input_fifo_count         = in_cnt;
    assign bus.output_fifo_dout         = dout_q;
    assign bus.output_fifo_empty        = out_empty;
    assign bus.output_fifo_almost_empty = (out_cnt <= AE_LEVEL);
    assign bus.eng_in_data              = line_q;
    assign bus.eng_in_valid             = eng_v_q;
    assign bus.lines_out                = lines_cnt;
    assign bus.err_unexpected           = err_q;
endmodule

// File: tb/tb_afu_stream_ctrl.sv
// Bench for afu_stream_ctrl: a 6-cycle XOR engine model, a queue-based model of
// which input line each engine issue and output read must carry, and directed jobs.
module tb_afu_stream_ctrl;
    localparam int DW  = 512;
    localparam int BDB = 5;
    localparam logic [DW-1:0] MASK = {16{32'h5A5AA5A5}};

    typedef struct {
        int   idx;
        logic byp;
    } src_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afu_stream_ctrl_if #(.DATA_WIDTH(DW), .BUFF_DEPTH_BITS(BDB)) bus();

    afu_stream_ctrl #(
        .DATA_WIDTH(DW), .BUFF_DEPTH_BITS(BDB),
        .ALMOST_FULL_MARGIN(4), .ALMOST_EMPTY_THRESHOLD(2)
    ) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] all_in[$];
    src_t exp_src[$];
    int eng_src[$];
    int next_take = 0;
    int eng_cnt = 0;
    int pop_cnt = 0;
    logic exp_err = 1'b0;
    logic spur = 1'b0;

    // Engine: fixed 6-cycle latency, result = line ^ MASK
    logic [5:0]    pv;
    logic [DW-1:0] pd [6];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else begin
            pv    <= {pv[4:0], bus.eng_in_valid};
            pd[0] <= bus.eng_in_data ^ MASK;
            for (int i = 1; i < 6; i++) pd[i] <= pd[i-1];
        end
    end
    assign bus.eng_out_valid = pv[5] | spur;
    assign bus.eng_out_data  = pd[5];

    task automatic chk_i(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : monitor
        logic pop, eiv;
        logic [DW-1:0] eid;
        src_t s;
        int k;
        pop = rst_n && bus.output_fifo_re && !bus.output_fifo_empty;
        eiv = rst_n && bus.eng_in_valid;
        eid = bus.eng_in_data;
        if (pop) pop_cnt++;
        if (eiv) eng_cnt++;
        #1;
        if (rst_n) begin
            if (eiv) begin
                chk_i("eng_in_expected", int'(eng_src.size() != 0), 1);
                if (eng_src.size() != 0) begin
                    k = eng_src.pop_front();
                    chk_d("eng_in_data", eid, all_in[k]);
                end
            end
            if (pop) begin
                chk_i("out_expected", int'(exp_src.size() != 0), 1);
                if (exp_src.size() != 0) begin
                    s = exp_src.pop_front();
                    chk_d("output_fifo_dout", bus.output_fifo_dout,
                          s.byp ? all_in[s.idx] : (all_in[s.idx] ^ MASK));
                end
            end
            chk_i("err_unexpected", int'(bus.err_unexpected), int'(exp_err));
        end
    end

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic feed(input int n);
        int pushed = 0;
        int guard = 0;
        while (pushed < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (!bus.input_fifo_full) begin
                bus.input_fifo_we  = 1'b1;
                bus.input_fifo_din = rand_line();
                all_in.push_back(bus.input_fifo_din);
                pushed++;
            end else begin
                bus.input_fifo_we = 1'b0;
            end
        end
        @(negedge clk);
        bus.input_fifo_we = 1'b0;
        if (pushed != n) chk_i("feed_timeout", pushed, n);
    endtask

    task automatic start_job(input int len, input logic mode, input logic accept);
        src_t s;
        @(negedge clk);
        bus.ctx_length = len;
        bus.ctx_mode   = mode;
        bus.ctx_start  = 1'b1;
        if (accept) begin
            for (int k = 0; k < len; k++) begin
                s.idx = next_take + k;
                s.byp = mode;
                exp_src.push_back(s);
                if (!mode) eng_src.push_back(next_take + k);
            end
            next_take += len;
        end
        @(negedge clk);
        bus.ctx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!bus.ctx_done && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk_i("ctx_done_rise", int'(bus.ctx_done), 1);
    endtask

    task automatic drain();
        int c = 0;
        bus.output_fifo_re = 1'b1;
        while (!bus.output_fifo_empty && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk_i("drain_empty", int'(bus.output_fifo_empty), 1);
        @(negedge clk);
        bus.output_fifo_re = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.input_fifo_we  = 1'b0;
        bus.input_fifo_din = '0;
        bus.output_fifo_re = 1'b0;
        bus.ctx_start      = 1'b0;
        bus.ctx_length     = '0;
        bus.ctx_mode       = 1'b0;
        spur               = 1'b0;
        all_in.delete();
        exp_src.delete();
        eng_src.delete();
        next_take = 0;
        exp_err   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_idle_outputs();
        chk_i("rst_in_full", int'(bus.input_fifo_full), 0);
        chk_i("rst_in_afull", int'(bus.input_fifo_almost_full), 0);
        chk_i("rst_in_count", int'(bus.input_fifo_count), 0);
        chk_i("rst_out_empty", int'(bus.output_fifo_empty), 1);
        chk_i("rst_out_aempty", int'(bus.output_fifo_almost_empty), 1);
        chk_i("rst_busy", int'(bus.ctx_busy), 0);
        chk_i("rst_done", int'(bus.ctx_done), 0);
        chk_i("rst_lines_out", int'(bus.lines_out), 0);
        chk_i("rst_eng_in_valid", int'(bus.eng_in_valid), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int eb, pb, p0, c;
        do_reset();
        check_idle_outputs();
        chk_i("rst_err", int'(bus.err_unexpected), 0);

        // Bypass job of 8 preloaded lines, output read continuously
        feed(8);
        chk_i("byp_in_count", int'(bus.input_fifo_count), 8);
        chk_i("byp_in_afull", int'(bus.input_fifo_almost_full), 0);
        bus.output_fifo_re = 1'b1;
        eb = eng_cnt; pb = pop_cnt;
        start_job(8, 1'b1, 1'b1);
        wait_done(100);
        chk_i("byp_lines_out", int'(bus.lines_out), 8);
        drain();
        chk_i("byp_pops", pop_cnt - pb, 8);
        chk_i("byp_eng_issues", eng_cnt - eb, 0);
        chk_i("byp_busy_after", int'(bus.ctx_busy), 0);

        // Zero-length job completes without touching the engine
        eb = eng_cnt;
        start_job(0, 1'b0, 1'b1);
        chk_i("len0_done", int'(bus.ctx_done), 1);
        chk_i("len0_busy", int'(bus.ctx_busy), 0);
        chk_i("len0_lines_out", int'(bus.lines_out), 0);
        repeat (5) @(negedge clk);
        chk_i("len0_eng_issues", eng_cnt - eb, 0);

        // Engine job of 100 with output blocked: credits cap issue at 32
        eb = eng_cnt; pb = pop_cnt;
        start_job(100, 1'b0, 1'b1);
        fork feed(100); join_none
        repeat (150) @(negedge clk);
        chk_i("eng_stall_issues", eng_cnt - eb, 32);
        chk_i("eng_stall_in_full", int'(bus.input_fifo_full), 1);
        chk_i("eng_stall_in_count", int'(bus.input_fifo_count), 32);
        chk_i("eng_stall_in_afull", int'(bus.input_fifo_almost_full), 1);
        chk_i("eng_stall_out_empty", int'(bus.output_fifo_empty), 0);
        chk_i("eng_stall_out_aempty", int'(bus.output_fifo_almost_empty), 0);
        chk_i("eng_stall_busy", int'(bus.ctx_busy), 1);
        chk_i("eng_stall_lines_out", int'(bus.lines_out), 32);
        bus.output_fifo_re = 1'b1;
        wait_done(1500);
        chk_i("eng_lines_out", int'(bus.lines_out), 100);
        drain();
        chk_i("eng_pops", pop_cnt - pb, 100);
        chk_i("eng_issues", eng_cnt - eb, 100);

        // Second start during RUN is ignored; 2 surplus lines stay in the input FIFO
        feed(22);
        chk_i("ign_in_count", int'(bus.input_fifo_count), 22);
        bus.output_fifo_re = 1'b1;
        eb = eng_cnt; pb = pop_cnt;
        start_job(20, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start_job(5, 1'b1, 1'b0);
        chk_i("ign_busy", int'(bus.ctx_busy), 1);
        wait_done(500);
        chk_i("ign_lines_out", int'(bus.lines_out), 20);
        drain();
        chk_i("ign_issues", eng_cnt - eb, 20);
        chk_i("ign_pops", pop_cnt - pb, 20);
        chk_i("ign_leftover", int'(bus.input_fifo_count), 2);

        // Credits exhausted, then pop and issue together every cycle
        eb = eng_cnt;
        start_job(64, 1'b1, 1'b1);
        fork feed(62); join_none
        repeat (100) @(negedge clk);
        chk_i("thr_eng_issues", eng_cnt - eb, 0);
        chk_i("thr_in_full", int'(bus.input_fifo_full), 1);
        chk_i("thr_lines_out", int'(bus.lines_out), 32);
        bus.output_fifo_re = 1'b1;
        p0 = pop_cnt;
        repeat (40) @(negedge clk);
        chk_i("thr_pops_40", pop_cnt - p0, 40);
        wait_done(300);
        chk_i("thr_total_lines", int'(bus.lines_out), 64);
        drain();

        // Reset in DRAIN, then a stray engine result
        feed(10);
        eb = eng_cnt;
        start_job(10, 1'b0, 1'b1);
        c = 0;
        while (eng_cnt - eb < 10 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk_i("rst_mid_issues", eng_cnt - eb, 10);
        repeat (2) @(negedge clk);
        chk_i("rst_mid_busy", int'(bus.ctx_busy), 1);
        chk_i("rst_mid_done", int'(bus.ctx_done), 0);
        do_reset();
        check_idle_outputs();
        @(negedge clk);
        spur = 1'b1;
        @(posedge clk);
        exp_err = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk_i("spur_err", int'(bus.err_unexpected), 1);
        chk_i("spur_out_empty", int'(bus.output_fifo_empty), 1);
        chk_i("spur_lines_out", int'(bus.lines_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
